// File: rtl/lcd_bus_pkg.sv
// Shared types and constants for the HD44780-style LCD bus responder.
// Also holds the address-counter wrap helpers used on the 2x40 DDRAM map.
package lcd_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_FILL,
        ST_BUSY
    } state_t;

    // One-hot instruction classes, selected by the highest set bit of the byte.
    localparam logic [7:0] OP_CLR   = 8'h01;
    localparam logic [7:0] OP_HOME  = 8'h02;
    localparam logic [7:0] OP_ENTRY = 8'h04;
    localparam logic [7:0] OP_DISP  = 8'h08;
    localparam logic [7:0] OP_SHIFT = 8'h10;
    localparam logic [7:0] OP_FUNC  = 8'h20;
    localparam logic [7:0] OP_CGRAM = 8'h40;
    localparam logic [7:0] OP_DDRAM = 8'h80;

    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE1_BASE = 7'h40;
    localparam logic [6:0] LINE0_END  = 7'h27;
    localparam logic [6:0] LINE1_END  = 7'h67;

    localparam logic [7:0] BLANK = 8'h20;

    function automatic logic [7:0] op_msb(input logic [7:0] d);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (d[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // Invalid gaps (0x28-0x3F, 0x68-0x7F) fall forward to the next line start.
    function automatic logic [6:0] ac_inc(input logic [6:0] ac);
        if (ac < LINE0_END)       return ac + 7'd1;
        else if (ac < LINE1_BASE) return LINE1_BASE;
        else if (ac < LINE1_END)  return ac + 7'd1;
        else                      return LINE0_BASE;
    endfunction

    function automatic logic [6:0] ac_dec(input logic [6:0] ac);
        if (ac == LINE0_BASE)      return LINE1_END;
        else if (ac == LINE1_BASE) return LINE0_END;
        else                       return ac - 7'd1;
    endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Pin synchronizer and E-strobe qualifier: emits one strobe per falling edge of E,
// either as a good write transfer or as a protocol error (runt pulse or read cycle).
module lcd_bus_sync #(
    parameter int E_MIN_CYC = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_lcd_rs,
    input  logic       i_lcd_rw,
    input  logic       i_lcd_e,
    input  logic [7:0] i_lcd_data,
    output logic       xfer_stb,
    output logic       err_stb,
    output logic       xfer_rs,
    output logic [7:0] xfer_data
);

    localparam int             WW   = $clog2(E_MIN_CYC + 1);
    localparam logic [WW-1:0]  EMAX = WW'(E_MIN_CYC);

    logic [1:0]    rs_ff, rw_ff, e_ff;
    logic [7:0]    d_ff1, d_ff2;
    logic          e_d;
    logic [WW-1:0] wcnt;
    logic          rw_smp;
    logic          fall, runt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_ff     <= '0;
            rw_ff     <= '0;
            e_ff      <= '0;
            d_ff1     <= '0;
            d_ff2     <= '0;
            e_d       <= 1'b0;
            wcnt      <= '0;
            xfer_rs   <= 1'b0;
            rw_smp    <= 1'b0;
            xfer_data <= '0;
        end else begin
            rs_ff <= {rs_ff[0], i_lcd_rs};
            rw_ff <= {rw_ff[0], i_lcd_rw};
            e_ff  <= {e_ff[0], i_lcd_e};
            d_ff1 <= i_lcd_data;
            d_ff2 <= d_ff1;
            e_d   <= e_ff[1];
            // Saturating width count; bus fields track E-high so the last high cycle wins.
            if (e_ff[1]) begin
                if (wcnt != EMAX) wcnt <= wcnt + WW'(1);
                xfer_rs   <= rs_ff[1];
                rw_smp    <= rw_ff[1];
                xfer_data <= d_ff2;
            end else begin
                wcnt <= '0;
            end
        end
    end

    assign fall     = e_d & ~e_ff[1];
    assign runt     = (wcnt != EMAX);
    assign xfer_stb = fall & ~runt & ~rw_smp;
    assign err_stb  = fall & (runt | rw_smp);

endmodule

// File: rtl/lcd_bus_rx.sv
// LCD write-bus responder: decodes instructions/data, emulates busy timing and
// keeps a 2x16 DDRAM shadow readable through a registered port.
module lcd_bus_rx
    import lcd_bus_pkg::*;
#(
    parameter int CMD_CYCLES = 2000,
    parameter int CLR_CYCLES = 76500,
    parameter int E_MIN_CYC  = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_lcd_rs,
    input  logic       i_lcd_rw,
    input  logic       i_lcd_e,
    input  logic [7:0] i_lcd_data,
    input  logic [4:0] i_rd_addr,
    output logic [7:0] o_rd_data,
    output logic       o_cmd_valid,
    output logic       o_wr_valid,
    output logic [7:0] o_xfer_byte,
    output logic       o_busy,
    output logic [6:0] o_ac,
    output logic       o_disp_on,
    output logic       o_err_overrun,
    output logic       o_err_proto
);

    localparam int MAXC      = (CLR_CYCLES > CMD_CYCLES) ? CLR_CYCLES : CMD_CYCLES;
    localparam int CW        = $clog2(MAXC + 1);
    localparam int FILL_TAIL = (CLR_CYCLES > 33) ? CLR_CYCLES - 33 : 0;

    state_t         state, state_nxt;
    logic           xfer_stb, err_stb, xfer_rs;
    logic [7:0]     xfer_data;
    logic           cur_rs;
    logic           id, cgram;
    logic [4:0]     fill_idx;
    logic [CW-1:0]  cnt;
    logic [31:0][7:0] shadow;
    logic [7:0]     op;
    logic           wr_hit;
    logic [4:0]     wr_idx;

    lcd_bus_sync #(.E_MIN_CYC(E_MIN_CYC)) u_sync (
        .clk        (clk),
        .rst        (rst),
        .i_lcd_rs   (i_lcd_rs),
        .i_lcd_rw   (i_lcd_rw),
        .i_lcd_e    (i_lcd_e),
        .i_lcd_data (i_lcd_data),
        .xfer_stb   (xfer_stb),
        .err_stb    (err_stb),
        .xfer_rs    (xfer_rs),
        .xfer_data  (xfer_data)
    );

    assign op          = op_msb(o_xfer_byte);
    assign o_busy      = (state != ST_IDLE);
    assign o_cmd_valid = (state == ST_EXEC) & ~cur_rs;
    assign o_wr_valid  = (state == ST_EXEC) &  cur_rs;

    // Only the first 16 columns of each line are visible and stored.
    always_comb begin
        wr_hit = 1'b0;
        wr_idx = {1'b0, o_ac[3:0]};
        if (o_ac[6:4] == 3'b000) begin
            wr_hit = 1'b1;
        end else if (o_ac[6:4] == 3'b100) begin
            wr_hit = 1'b1;
            wr_idx = {1'b1, o_ac[3:0]};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (xfer_stb) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = (!cur_rs && op == OP_CLR) ? ST_FILL : ST_BUSY;
            ST_FILL: if (fill_idx == 5'd31) state_nxt = ST_BUSY;
            ST_BUSY: if (cnt <= CW'(1)) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            cur_rs        <= 1'b0;
            o_xfer_byte   <= '0;
            o_ac          <= '0;
            id            <= 1'b1;
            cgram         <= 1'b0;
            o_disp_on     <= 1'b0;
            o_err_proto   <= 1'b0;
            o_err_overrun <= 1'b0;
            fill_idx      <= '0;
            cnt           <= '0;
        end else begin
            state         <= state_nxt;
            o_err_overrun <= xfer_stb && (state != ST_IDLE);
            if (err_stb) o_err_proto <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (xfer_stb) begin
                        cur_rs      <= xfer_rs;
                        o_xfer_byte <= xfer_data;
                    end
                end
                ST_EXEC: begin
                    // EXEC is the first busy cycle, so the tail is one shorter.
                    cnt      <= CW'(CMD_CYCLES - 1);
                    fill_idx <= '0;
                    if (cur_rs) begin
                        if (!cgram) o_ac <= id ? ac_inc(o_ac) : ac_dec(o_ac);
                    end else begin
                        case (op)
                            OP_CLR:   begin o_ac <= LINE0_BASE; id <= 1'b1; end
                            OP_HOME:  begin o_ac <= LINE0_BASE; cnt <= CW'(CLR_CYCLES - 1); end
                            OP_ENTRY: id <= o_xfer_byte[1];
                            OP_DISP:  o_disp_on <= o_xfer_byte[2];
                            OP_SHIFT: if (!o_xfer_byte[3])
                                          o_ac <= o_xfer_byte[2] ? ac_inc(o_ac) : ac_dec(o_ac);
                            OP_FUNC:  if (!o_xfer_byte[4]) o_err_proto <= 1'b1;
                            OP_CGRAM: cgram <= 1'b1;
                            OP_DDRAM: begin o_ac <= o_xfer_byte[6:0]; cgram <= 1'b0; end
                            default:  ;
                        endcase
                    end
                end
                ST_FILL: begin
                    fill_idx <= fill_idx + 5'd1;
                    if (fill_idx == 5'd31) cnt <= CW'(FILL_TAIL);
                end
                ST_BUSY: begin
                    if (cnt != '0) cnt <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= {32{BLANK}};
        end else if (state == ST_FILL) begin
            shadow[fill_idx] <= BLANK;
        end else if (state == ST_EXEC && cur_rs && !cgram && wr_hit) begin
            shadow[wr_idx] <= o_xfer_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) o_rd_data <= BLANK;
        else     o_rd_data <= shadow[i_rd_addr];
    end

endmodule

// File: tb/tb_lcd_bus_rx.sv
// Self-checking bench for lcd_bus_rx: directed scenarios plus a randomized
// instruction/data stream compared against a display-level reference model.
module tb_lcd_bus_rx;

    localparam int CMD  = 200;
    localparam int CLR  = 600;
    localparam int EMIN = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_lcd_rs, i_lcd_rw, i_lcd_e;
    logic [7:0] i_lcd_data;
    logic [4:0] i_rd_addr;
    logic [7:0] o_rd_data;
    logic       o_cmd_valid, o_wr_valid;
    logic [7:0] o_xfer_byte;
    logic       o_busy;
    logic [6:0] o_ac;
    logic       o_disp_on, o_err_overrun, o_err_proto;

    int checks = 0;
    int errors = 0;

    lcd_bus_rx #(.CMD_CYCLES(CMD), .CLR_CYCLES(CLR), .E_MIN_CYC(EMIN)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_lcd_rs      (i_lcd_rs),
        .i_lcd_rw      (i_lcd_rw),
        .i_lcd_e       (i_lcd_e),
        .i_lcd_data    (i_lcd_data),
        .i_rd_addr     (i_rd_addr),
        .o_rd_data     (o_rd_data),
        .o_cmd_valid   (o_cmd_valid),
        .o_wr_valid    (o_wr_valid),
        .o_xfer_byte   (o_xfer_byte),
        .o_busy        (o_busy),
        .o_ac          (o_ac),
        .o_disp_on     (o_disp_on),
        .o_err_overrun (o_err_overrun),
        .o_err_proto   (o_err_proto)
    );

    always #5 clk = ~clk;

    // Pulse counters and busy-length recorder
    int n_cmd = 0, n_wr = 0, n_ovr = 0, busy_run = 0, last_busy = 0;
    always @(negedge clk) begin
        if (rst) begin
            busy_run <= 0;
        end else begin
            if (o_cmd_valid)   n_cmd <= n_cmd + 1;
            if (o_wr_valid)    n_wr  <= n_wr + 1;
            if (o_err_overrun) n_ovr <= n_ovr + 1;
            if (o_busy) busy_run <= busy_run + 1;
            else if (busy_run != 0) begin
                last_busy <= busy_run;
                busy_run  <= 0;
            end
        end
    end

    // Reference model: display as seen by a user of the LCD
    logic [7:0] m_sh [32];
    int         m_ac;
    bit         m_id, m_cg, m_disp, m_proto;

    function automatic int m_inc(input int a);
        if (a < 'h27) return a + 1;
        if (a < 'h40) return 'h40;
        if (a < 'h67) return a + 1;
        return 0;
    endfunction

    function automatic int m_dec(input int a);
        if (a == 0)    return 'h67;
        if (a == 'h40) return 'h27;
        return a - 1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_sh[i] = 8'h20;
        m_ac = 0; m_id = 1; m_cg = 0; m_disp = 0; m_proto = 0;
    endtask

    task automatic m_apply(input bit rs, input logic [7:0] d);
        if (rs) begin
            if (!m_cg) begin
                if (m_ac < 16) m_sh[m_ac] = d;
                else if (m_ac >= 'h40 && m_ac < 'h50) m_sh[m_ac - 'h40 + 16] = d;
                m_ac = m_id ? m_inc(m_ac) : m_dec(m_ac);
            end
        end else if (d >= 8'h80) begin
            m_ac = int'(d) - 'h80; m_cg = 0;
        end else if (d >= 8'h40) m_cg = 1;
        else if (d >= 8'h20) begin
            if (!d[4]) m_proto = 1;
        end else if (d >= 8'h10) begin
            if (!d[3]) m_ac = d[2] ? m_inc(m_ac) : m_dec(m_ac);
        end else if (d >= 8'h08) m_disp = d[2];
        else if (d >= 8'h04) m_id = d[1];
        else if (d >= 8'h02) m_ac = 0;
        else if (d == 8'h01) begin
            for (int i = 0; i < 32; i++) m_sh[i] = 8'h20;
            m_ac = 0; m_id = 1;
        end
    endtask

    task automatic xfer(input bit rs, input bit rw, input logic [7:0] d, input int w);
        @(negedge clk);
        i_lcd_rs = rs; i_lcd_rw = rw; i_lcd_data = d; i_lcd_e = 1'b1;
        repeat (w) @(negedge clk);
        i_lcd_e = 1'b0;
        repeat (4) @(negedge clk);
        i_lcd_rw = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (o_busy && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (o_busy) begin
            checks++; errors++;
            $display("FAIL wait_idle: busy still %0b after %0d cycles, need 0", o_busy, t);
        end
        @(negedge clk);
    endtask

    task automatic do_op(input bit rs, input logic [7:0] d, input int w);
        xfer(rs, 1'b0, d, w);
        m_apply(rs, d);
        wait_idle();
    endtask

    task automatic rd(input int idx, output logic [7:0] v);
        @(negedge clk);
        i_rd_addr = 5'(idx);
        @(negedge clk);
        v = o_rd_data;
    endtask

    task automatic check_shadow(input string name);
        logic [7:0] v;
        for (int i = 0; i < 32; i++) begin
            rd(i, v);
            checks++;
            if (v !== m_sh[i]) begin
                errors++;
                $display("FAIL %s shadow[%0d]: got %h expected %h", name, i, v, m_sh[i]);
            end
        end
    endtask

    task automatic check_ac(input string name);
        checks++;
        if (o_ac !== 7'(m_ac)) begin
            errors++;
            $display("FAIL %s ac: got %h expected %h", name, o_ac, 7'(m_ac));
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check_val({name, " rd_data"}, int'(o_rd_data), 'h20);
        check_bit({name, " busy"}, o_busy, 1'b0);
        check_val({name, " ac"}, int'(o_ac), 0);
        check_bit({name, " disp_on"}, o_disp_on, 1'b0);
        check_bit({name, " proto"}, o_err_proto, 1'b0);
        check_bit({name, " overrun"}, o_err_overrun, 1'b0);
        check_bit({name, " cmd_valid"}, o_cmd_valid, 1'b0);
        check_bit({name, " wr_valid"}, o_wr_valid, 1'b0);
        check_val({name, " xfer_byte"}, int'(o_xfer_byte), 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_lcd_rs = 0; i_lcd_rw = 0; i_lcd_e = 0; i_lcd_data = 0; i_rd_addr = 0;
        m_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_shadow("reset");
    endtask

    task automatic test_init();
        int c0 = n_cmd;
        do_op(0, 8'h38, 500);
        do_op(0, 8'h0C, 500);
        do_op(0, 8'h06, 500);
        check_val("cmd busy length", last_busy, CMD);
        do_op(0, 8'h01, 500);
        check_val("clear busy length", last_busy, CLR);
        check_val("init cmd pulses", n_cmd - c0, 4);
        check_val("init xfer_byte", int'(o_xfer_byte), 'h01);
        check_bit("init disp_on", o_disp_on, 1'b1);
        check_bit("init disp_on model", o_disp_on, m_disp);
        check_val("init ac", int'(o_ac), 0);
        check_bit("init proto", o_err_proto, 1'b0);
        check_shadow("init");
    endtask

    task automatic test_ddram_write();
        logic [7:0] v;
        int w0 = n_wr;
        do_op(0, 8'h80, 20);
        do_op(1, 8'h41, 20);
        do_op(1, 8'h42, 20);
        do_op(0, 8'hC0, 20);
        do_op(1, 8'h58, 20);
        rd(0, v);  check_val("ddram rd0", int'(v), 'h41);
        rd(1, v);  check_val("ddram rd1", int'(v), 'h42);
        rd(16, v); check_val("ddram rd16", int'(v), 'h58);
        check_val("ddram ac", int'(o_ac), 'h41);
        check_val("ddram wr pulses", n_wr - w0, 3);
        check_val("ddram xfer_byte", int'(o_xfer_byte), 'h58);
    endtask

    task automatic test_wrap();
        do_op(0, 8'hA7, 20);
        do_op(1, 8'h57, 20);
        check_val("wrap 27->40", int'(o_ac), 'h40);
        do_op(0, 8'hE7, 20);
        do_op(1, 8'h56, 20);
        check_val("wrap 67->00", int'(o_ac), 0);
        check_shadow("wrap");
    endtask

    task automatic test_overrun();
        int o0, w0;
        do_op(0, 8'h85, 20);
        o0 = n_ovr; w0 = n_wr;
        xfer(1, 0, 8'h51, 20);
        m_apply(1, 8'h51);
        repeat (6) @(negedge clk);
        xfer(1, 0, 8'h5A, 20);
        wait_idle();
        check_val("overrun pulses", n_ovr - o0, 1);
        check_val("overrun wr pulses", n_wr - w0, 1);
        check_val("overrun xfer_byte", int'(o_xfer_byte), 'h51);
        check_ac("overrun");
        check_shadow("overrun");
    endtask

    task automatic test_proto();
        int w0 = n_wr, c0 = n_cmd, ac0;
        check_bit("proto clean", o_err_proto, 1'b0);
        xfer(1, 0, 8'h52, EMIN - 1);
        repeat (4) @(negedge clk);
        check_bit("runt11 proto", o_err_proto, 1'b1);
        check_bit("runt11 busy", o_busy, 1'b0);
        xfer(1, 0, 8'h53, 5);
        repeat (4) @(negedge clk);
        check_bit("runt5 proto", o_err_proto, 1'b1);
        check_val("runt wr pulses", n_wr - w0, 0);
        check_val("runt cmd pulses", n_cmd - c0, 0);
        m_proto = 1;
        ac0 = int'(o_ac);
        xfer(0, 1, 8'h80, 20);
        repeat (4) @(negedge clk);
        check_bit("rw proto sticky", o_err_proto, m_proto);
        check_val("rw cmd pulses", n_cmd - c0, 0);
        check_val("rw ac unchanged", int'(o_ac), ac0);
        check_shadow("proto");
    endtask

    task automatic test_random();
        logic [7:0] d;
        int r, w;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            w = $urandom_range(EMIN, 40);
            if (r <= 4) begin
                d = 8'($urandom_range('h21, 'h7E));
                do_op(1, d, w);
            end else begin
                case (r)
                    5: d = 8'h80 | ($urandom_range(0, 1) ? 8'h40 : 8'h00) | 8'($urandom_range(0, 'h27));
                    6: d = 8'h04 | 8'($urandom_range(0, 3));
                    7: d = 8'h10 | 8'($urandom_range(0, 15));
                    8: d = 8'h40 | 8'($urandom_range(0, 63));
                    default: d = 8'h08 | 8'($urandom_range(0, 7));
                endcase
                do_op(0, d, w);
            end
            check_ac("random");
        end
        check_bit("random disp_on", o_disp_on, m_disp);
        check_shadow("random");
    endtask

    task automatic test_reset_mid_fill();
        xfer(0, 0, 8'h01, 20);
        repeat (10) @(negedge clk);
        check_bit("fill in progress", o_busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid-fill reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_bit("post-reset busy", o_busy, 1'b0);
        end
        check_shadow("mid-fill reset");
    endtask

    initial begin
        test_reset();
        test_init();
        test_ddram_write();
        test_wrap();
        test_overrun();
        test_proto();
        test_random();
        test_reset_mid_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
